ip_v4_header_insert: RTL and testbench

IP_V4_HEADER_INSERT -- requirements
Module: ip_v4_header_insert

---
 rtl/ip_v4_pkg.sv | 14 +
 rtl/ip_v4_header_insert_sync_fifo.sv | 60 ++++++
 rtl/ip_v4_header_insert.sv | 192 +++++++++++++++++++
 tb/tb_ip_v4_header_insert.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_v4_pkg.sv
// rtl/ip_v4_pkg.sv - shared constants and FSM state type for the IPv4 header checksum inserter
package ip_v4_pkg;
   localparam int HDR_WORDS     = 5;
   localparam int CSUM_WORD_IDX = 2;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      WAIT_CRC,
      EMIT_HDR,
      EMIT_PAY,
      DONE
   } state_t;
endpackage

// File: rtl/ip_v4_header_insert_sync_fifo.sv
// rtl/ip_v4_header_insert_sync_fifo.sv - synchronous FIFO holding payload words with their last flag
module sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
   end
endmodule

// File: rtl/ip_v4_header_insert.sv
// rtl/ip_v4_header_insert.sv - buffers an IPv4 packet and patches the header checksum into word 2
module ip_v4_header_insert
   import ip_v4_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] d_in,
   input  logic        d_in_vld,
   input  logic        d_in_last,
   input  logic [15:0] crc,
   input  logic        crc_vld,
   output logic [31:0] d_out,
   output logic        d_out_vld,
   input  logic        d_out_rdy,
   output logic        d_out_sop,
   output logic        d_out_eop,
   output logic        err
);
   localparam logic [2:0] LAST_IDX = 3'(HDR_WORDS - 1);
   localparam logic [2:0] CSUM_IDX = 3'(CSUM_WORD_IDX);

   state_t                        state_q, state_d, st_e;
   logic [2:0]                    cnt_q, cnt_d, cnt_e, idx_q, idx_d;
   logic [HDR_WORDS-1:0][31:0]    hdr_q, hdr_d;
   logic                          hdr_done_q, hdr_done_d, done_e;
   logic                          crc_held_q, crc_held_d;
   logic [15:0]                   crc_q, crc_d;
   logic                          last4_q, last4_d;
   logic                          ended_q, ended_d, ended_e;
   logic                          err_q, err_d;
   logic                          fifo_clr, fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [32:0]                   fifo_rdata;

   sync_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (fifo_clr),
      .push  (fifo_push),
      .wdata ({d_in_last, d_in}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hdr_d      = hdr_q;
      hdr_done_d = hdr_done_q;
      crc_held_d = crc_held_q;
      crc_d      = crc_q;
      last4_d    = last4_q;
      ended_d    = ended_q;
      idx_d      = idx_q;
      err_d      = 1'b0;
      fifo_clr   = 1'b0;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      // *_e is the capture context this cycle; start makes the concurrent word word 0
      st_e       = state_q;
      cnt_e      = cnt_q;
      done_e     = hdr_done_q;
      ended_e    = ended_q;

      if (start) begin
         st_e       = HDR;
         cnt_e      = '0;
         done_e     = 1'b0;
         ended_e    = 1'b0;
         state_d    = HDR;
         cnt_d      = '0;
         hdr_done_d = 1'b0;
         crc_held_d = 1'b0;
         last4_d    = 1'b0;
         ended_d    = 1'b0;
         idx_d      = '0;
         fifo_clr   = 1'b1;
      end else begin
         if (crc_vld && (state_q == HDR || state_q == WAIT_CRC)) begin
            crc_d      = crc;
            crc_held_d = 1'b1;
         end
         unique case (state_q)
            HDR, WAIT_CRC: begin
               if (hdr_done_q && crc_held_q) begin
                  state_d = EMIT_HDR;
                  idx_d   = '0;
               end else if (hdr_done_q) begin
                  state_d = WAIT_CRC;
               end
            end
            EMIT_HDR: begin
               if (d_out_rdy) begin
                  idx_d = idx_q + 3'd1;
                  if (idx_q == LAST_IDX)
                     state_d = EMIT_PAY;
                  else if (idx_q == LAST_IDX - 3'd1 && last4_q)
                     state_d = DONE;
               end
            end
            EMIT_PAY: begin
               if (d_out_rdy && !fifo_empty) begin
                  fifo_pop = 1'b1;
                  if (fifo_rdata[32]) state_d = IDLE;
               end
            end
            DONE: begin
               if (d_out_rdy) state_d = IDLE;
            end
            default: ;
         endcase
      end

      if (d_in_vld && !ended_e && st_e != IDLE && st_e != DONE) begin
         if (d_in_last) ended_d = 1'b1;
         if (!done_e) begin
            hdr_d[cnt_e] = d_in;
            cnt_d        = cnt_e + 3'd1;
            if (cnt_e == LAST_IDX) begin
               hdr_done_d = 1'b1;
               last4_d    = d_in_last;
            end else if (d_in_last) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end else begin
            fifo_push = 1'b1;
            if (fifo_full && !fifo_pop) err_d = 1'b1;
         end
      end
   end

   always_comb begin
      d_out_vld = 1'b0;
      d_out     = '0;
      d_out_sop = 1'b0;
      d_out_eop = 1'b0;
      unique case (state_q)
         EMIT_HDR: begin
            d_out_vld = 1'b1;
            d_out     = hdr_q[idx_q];
            if (idx_q == CSUM_IDX) d_out[15:0] = crc_q;
            d_out_sop = (idx_q == 3'd0);
         end
         DONE: begin
            d_out_vld = 1'b1;
            d_out     = hdr_q[LAST_IDX];
            d_out_eop = 1'b1;
         end
         EMIT_PAY: begin
            if (!fifo_empty) begin
               d_out_vld = 1'b1;
               d_out     = fifo_rdata[31:0];
               d_out_eop = fifo_rdata[32];
            end
         end
         default: ;
      endcase
   end

   assign err = err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hdr_q      <= '0;
         hdr_done_q <= 1'b0;
         crc_held_q <= 1'b0;
         crc_q      <= '0;
         last4_q    <= 1'b0;
         ended_q    <= 1'b0;
         idx_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hdr_q      <= hdr_d;
         hdr_done_q <= hdr_done_d;
         crc_held_q <= crc_held_d;
         crc_q      <= crc_d;
         last4_q    <= last4_d;
         ended_q    <= ended_d;
         idx_q      <= idx_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_ip_v4_header_insert.sv
// tb/tb_ip_v4_header_insert.sv - directed self-checking bench for ip_v4_header_insert
module tb_ip_v4_header_insert;
   localparam logic [31:0] GOLD [8] = '{
      32'h4500_0073, 32'h0000_4000, 32'h4011_0000, 32'hc0a8_0001,
      32'hc0a8_00c7, 32'h0035_e97c, 32'h005f_279f, 32'h1e4b_8180
   };

   logic        clk = 1'b0;
   logic        reset, start, d_in_vld, d_in_last, crc_vld, d_out_rdy;
   logic        d_out_vld, d_out_sop, d_out_eop, err;
   logic [31:0] d_in, d_out;
   logic [15:0] crc;

   int          n_checks = 0;
   int          n_errs   = 0;
   int          rdy_mode = 0;
   int          err_cnt = 0, vld_cnt = 0, stab_viol = 0, hold_cnt = 0;
   logic [33:0] out_q [$];
   logic        hold_prev = 1'b0;
   logic [33:0] prev_w = '0;

   always #5 clk = ~clk;

   ip_v4_header_insert #(.FIFO_DEPTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .d_in      (d_in),
      .d_in_vld  (d_in_vld),
      .d_in_last (d_in_last),
      .crc       (crc),
      .crc_vld   (crc_vld),
      .d_out     (d_out),
      .d_out_vld (d_out_vld),
      .d_out_rdy (d_out_rdy),
      .d_out_sop (d_out_sop),
      .d_out_eop (d_out_eop),
      .err       (err)
   );

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       d_out_rdy = 1'b1;
         1:       d_out_rdy = 1'b0;
         default: d_out_rdy = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clk) begin
      if (d_out_vld && d_out_rdy) out_q.push_back({d_out_sop, d_out_eop, d_out});
      if (d_out_vld) vld_cnt++;
      if (err) err_cnt++;
      if (hold_prev && (!d_out_vld || {d_out_sop, d_out_eop, d_out} != prev_w)) stab_viol++;
      hold_prev = d_out_vld && !d_out_rdy && !reset;
      if (hold_prev) hold_cnt++;
      prev_w = {d_out_sop, d_out_eop, d_out};
   end

   function automatic logic [31:0] gold_out(input int i);
      return (i == 2) ? 32'h4011_b861 : GOLD[i];
   endfunction

   task automatic step(input logic s, input logic v, input logic [31:0] d, input logic l,
                       input logic cv, input logic [15:0] c);
      start = s; d_in_vld = v; d_in = d; d_in_last = l; crc_vld = cv; crc = c;
      @(posedge clk); #1;
      start = 0; d_in_vld = 0; d_in = '0; d_in_last = 0; crc_vld = 0; crc = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic send_gold(input int crc_delay, input bit last_at4);
      int          npay;
      logic [31:0] w;
      npay = last_at4 ? 0 : 3;
      for (int i = 0; i < 5; i++) step(i == 0, 1, GOLD[i], last_at4 && i == 4, 0, '0);
      for (int k = 0; k <= ((crc_delay > npay - 1) ? crc_delay : npay - 1); k++) begin
         if (k < npay) w = GOLD[5 + k]; else w = '0;
         step(0, k < npay, w, k == npay - 1, k == crc_delay, 16'hb861);
      end
   endtask

   task automatic wait_words(input int base, input int n, input int budget);
      int k = 0;
      while (out_q.size() < base + n && k < budget) begin @(posedge clk); #1; k++; end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 0; d_in_vld = 0; d_in = '0; d_in_last = 0; crc_vld = 0; crc = '0;
      @(posedge clk); @(negedge clk);
      n_checks++; if (d_out_vld !== 1'b0) begin n_errs++; $display("FAIL reset_vld: got %b want 0", d_out_vld); end
      n_checks++; if (d_out !== 32'h0) begin n_errs++; $display("FAIL reset_dout: got %h want 0", d_out); end
      n_checks++; if ({d_out_sop, d_out_eop} !== 2'b00) begin n_errs++; $display("FAIL reset_sop_eop: got %b want 00", {d_out_sop, d_out_eop}); end
      n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL reset_err: got %b want 0", err); end
      reset_dut();
   endtask

   task automatic test_reset_mid();
      int v0;
      reset_dut();
      v0 = vld_cnt;
      for (int i = 0; i < 5; i++) step(i == 0, 1, GOLD[i], 0, 0, '0);
      step(0, 1, GOLD[5], 0, 1, 16'hb861);
      reset_dut();
      idle(20);
      n_checks++; if (vld_cnt - v0 !== 0) begin n_errs++; $display("FAIL reset_mid_vld: got %0d valid cycles want 0", vld_cnt - v0); end
   endtask

   task automatic test_gold();
      int base, e0;
      reset_dut();
      base = out_q.size(); e0 = err_cnt;
      send_gold(0, 0);
      wait_words(base, 8, 100);
      idle(10);
      n_checks++; if (out_q.size() - base !== 8) begin n_errs++; $display("FAIL gold_count: got %0d want 8", out_q.size() - base); end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (out_q[base + i] !== {i == 0, i == 7, gold_out(i)}) begin
            n_errs++; $display("FAIL gold_word%0d: got %h want %h", i, out_q[base + i], {i == 0, i == 7, gold_out(i)});
         end
      end
      n_checks++; if (err_cnt - e0 !== 0) begin n_errs++; $display("FAIL gold_err: got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_late_crc_random_rdy();
      int base, s0, h0;
      reset_dut();
      base = out_q.size(); s0 = stab_viol; h0 = hold_cnt;
      rdy_mode = 2;
      send_gold(20, 0);
      wait_words(base, 8, 300);
      idle(10);
      rdy_mode = 0;
      idle(2);
      n_checks++; if (out_q.size() - base !== 8) begin n_errs++; $display("FAIL late_count: got %0d want 8", out_q.size() - base); end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (out_q[base + i] !== {i == 0, i == 7, gold_out(i)}) begin
            n_errs++; $display("FAIL late_word%0d: got %h want %h", i, out_q[base + i], {i == 0, i == 7, gold_out(i)});
         end
      end
      n_checks++; if (stab_viol - s0 !== 0) begin n_errs++; $display("FAIL late_stable: got %0d changes while held want 0", stab_viol - s0); end
      n_checks++; if (hold_cnt - h0 <= 0) begin n_errs++; $display("FAIL late_hold_seen: got %0d held cycles want >0", hold_cnt - h0); end
   endtask

   task automatic test_five_word();
      int base, e0;
      reset_dut();
      base = out_q.size(); e0 = err_cnt;
      send_gold(0, 1);
      wait_words(base, 5, 100);
      step(0, 1, 32'hdead_beef, 0, 0, '0);
      step(0, 1, 32'hfeed_f00d, 1, 0, '0);
      idle(20);
      n_checks++; if (out_q.size() - base !== 5) begin n_errs++; $display("FAIL five_count: got %0d want 5", out_q.size() - base); end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (out_q[base + i] !== {i == 0, i == 4, gold_out(i)}) begin
            n_errs++; $display("FAIL five_word%0d: got %h want %h", i, out_q[base + i], {i == 0, i == 4, gold_out(i)});
         end
      end
      n_checks++; if (err_cnt - e0 !== 0) begin n_errs++; $display("FAIL five_err: got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_short_packet();
      int base, e0, v0;
      reset_dut();
      e0 = err_cnt; v0 = vld_cnt;
      step(1, 1, GOLD[0], 0, 0, '0);
      step(0, 1, GOLD[1], 0, 0, '0);
      step(0, 1, GOLD[2], 1, 1, 16'h1234);
      idle(15);
      n_checks++; if (err_cnt - e0 !== 1) begin n_errs++; $display("FAIL short_err: got %0d pulses want 1", err_cnt - e0); end
      n_checks++; if (vld_cnt - v0 !== 0) begin n_errs++; $display("FAIL short_vld: got %0d valid cycles want 0", vld_cnt - v0); end
      base = out_q.size();
      send_gold(0, 0);
      wait_words(base, 8, 100);
      idle(5);
      n_checks++; if (out_q.size() - base !== 8) begin n_errs++; $display("FAIL short_next_count: got %0d want 8", out_q.size() - base); end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (out_q[base + i] !== {i == 0, i == 7, gold_out(i)}) begin
            n_errs++; $display("FAIL short_next_word%0d: got %h want %h", i, out_q[base + i], {i == 0, i == 7, gold_out(i)});
         end
      end
   endtask

   task automatic test_overflow();
      int          base, e0, s0;
      logic [33:0] exp;
      reset_dut();
      rdy_mode = 1;
      idle(1);
      base = out_q.size(); e0 = err_cnt; s0 = stab_viol;
      for (int i = 0; i < 5; i++) step(i == 0, 1, GOLD[i], 0, 0, '0);
      for (int k = 0; k < 40; k++) step(0, 1, 32'h1000_0000 + k, k == 39, k == 0, 16'hb861);
      idle(5);
      n_checks++; if (err_cnt - e0 !== 24) begin n_errs++; $display("FAIL ovf_err: got %0d pulses want 24", err_cnt - e0); end
      n_checks++; if (out_q.size() - base !== 0) begin n_errs++; $display("FAIL ovf_held: got %0d words want 0", out_q.size() - base); end
      rdy_mode = 0;
      idle(40);
      n_checks++; if (out_q.size() - base !== 21) begin n_errs++; $display("FAIL ovf_count: got %0d want 21", out_q.size() - base); end
      for (int i = 0; i < 21; i++) begin
         exp = (i < 5) ? {i == 0, 1'b0, gold_out(i)} : {2'b00, 32'h1000_0000 + 32'(i - 5)};
         n_checks++;
         if (out_q[base + i] !== exp) begin
            n_errs++; $display("FAIL ovf_word%0d: got %h want %h", i, out_q[base + i], exp);
         end
      end
      n_checks++; if (stab_viol - s0 !== 0) begin n_errs++; $display("FAIL ovf_stable: got %0d changes while held want 0", stab_viol - s0); end
   endtask

   task automatic test_restart();
      int base, e0, sz, old_n, old_eops;
      reset_dut();
      rdy_mode = 1;
      idle(1);
      base = out_q.size(); e0 = err_cnt;
      for (int i = 0; i < 5; i++) step(i == 0, 1, 32'ha000_0000 + i, 0, 0, '0);
      for (int k = 0; k < 10; k++) step(0, 1, 32'hb000_0000 + k, k == 9, k == 0, 16'h1234);
      rdy_mode = 0;
      wait_words(base, 7, 50);
      send_gold(0, 0);
      idle(40);
      sz = out_q.size() - base;
      old_n = sz - 8;
      n_checks++; if (old_n < 7 || old_n > 14) begin n_errs++; $display("FAIL restart_old_count: got %0d want 7..14", old_n); end
      old_eops = 0;
      for (int i = 0; i < old_n; i++) if (out_q[base + i][32]) old_eops++;
      n_checks++; if (old_eops !== 0) begin n_errs++; $display("FAIL restart_old_eop: got %0d want 0", old_eops); end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (out_q[base + old_n + i] !== {i == 0, i == 7, gold_out(i)}) begin
            n_errs++; $display("FAIL restart_word%0d: got %h want %h", i, out_q[base + old_n + i], {i == 0, i == 7, gold_out(i)});
         end
      end
      n_checks++; if (err_cnt - e0 !== 0) begin n_errs++; $display("FAIL restart_err: got %0d want 0", err_cnt - e0); end
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_gold();
      test_late_crc_random_rdy();
      test_five_word();
      test_short_packet();
      test_overflow();
      test_restart();
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule
